// File: rtl/hazard_controller.sv
// Pipeline hazard sequencing: load-use bubbles, branch flushes, and a multiply/divide
// hold state with a watchdog, plus stall and flush performance counters.
module hazard_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       EX_RD,
    input  logic             EX_MEM_READ,
    input  logic             BRANCH_TAKEN,
    input  logic             MD_START,
    input  logic             MD_DONE,
    input  logic             CLR_COUNTERS,
    output logic             PC_WRITE_EN,
    output logic             IF_ID_WRITE_EN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic             EX_HOLD,
    output logic             MEM_BUBBLE,
    output logic             MD_ERROR,
    output logic [CNT_W-1:0] STALL_CYCLES,
    output logic [CNT_W-1:0] FLUSH_COUNT
);

    // state   | meaning
    // RUN     | normal issue; branch flush, md entry and load-use bubble evaluated
    // MD_WAIT | pipeline held until MD_DONE or the watchdog expires
    typedef enum logic {RUN, MD_WAIT} state_t;

    localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt;
    logic          load_use;
    logic          md_enter;
    logic          timeout_hit;
    logic          flush_evt;

    always_comb begin
        load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                   ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                    (ID_USES_RS2 && (ID_RS2 == EX_RD)));
        md_enter    = (state == RUN) && !BRANCH_TAKEN && MD_START && !MD_DONE;
        timeout_hit = (state == MD_WAIT) && !MD_DONE && (tcnt == TW'(MD_TIMEOUT - 1));
        flush_evt   = (state == RUN) && BRANCH_TAKEN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (md_enter) state_nxt = MD_WAIT;
            MD_WAIT: if (MD_DONE || timeout_hit) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        PC_WRITE_EN    = 1'b1;
        IF_ID_WRITE_EN = 1'b1;
        IF_ID_FLUSH    = 1'b0;
        ID_EX_BUBBLE   = 1'b0;
        EX_HOLD        = 1'b0;
        MEM_BUBBLE     = 1'b0;
        if (RST) begin
            PC_WRITE_EN    = 1'b0;
            IF_ID_WRITE_EN = 1'b0;
            IF_ID_FLUSH    = 1'b1;
            ID_EX_BUBBLE   = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (BRANCH_TAKEN) begin
                        IF_ID_FLUSH  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end else if (md_enter) begin
                        PC_WRITE_EN    = 1'b0;
                        IF_ID_WRITE_EN = 1'b0;
                        EX_HOLD        = 1'b1;
                        MEM_BUBBLE     = 1'b1;
                    end else if (!MD_START && load_use) begin
                        PC_WRITE_EN    = 1'b0;
                        IF_ID_WRITE_EN = 1'b0;
                        ID_EX_BUBBLE   = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!MD_DONE && !timeout_hit) begin
                        PC_WRITE_EN    = 1'b0;
                        IF_ID_WRITE_EN = 1'b0;
                        EX_HOLD        = 1'b1;
                        MEM_BUBBLE     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timeout counter is zero on the first MD_WAIT cycle; expiry releases on MD_TIMEOUT-1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tcnt <= '0;
        end else if (state == RUN) begin
            tcnt <= '0;
        end else if (!MD_DONE && !timeout_hit) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)              MD_ERROR <= 1'b0;
        else if (timeout_hit) MD_ERROR <= 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STALL_CYCLES <= '0;
            FLUSH_COUNT  <= '0;
        end else if (CLR_COUNTERS) begin
            STALL_CYCLES <= '0;
            FLUSH_COUNT  <= '0;
        end else begin
            if (!PC_WRITE_EN) STALL_CYCLES <= STALL_CYCLES + 1'b1;
            if (flush_evt)    FLUSH_COUNT  <= FLUSH_COUNT + 1'b1;
        end
    end

endmodule
